// File: rtl/prog_loader.sv
// Boot-time program loader: assembles MSB-first 32-bit words from a byte stream into instruction memory.
// Optional trailing XOR checksum byte enabled by defining LOADER_CSUM_EN.
module prog_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              load_start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
`ifdef LOADER_CSUM_EN
    CSUM  = 3'd4,
`endif
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam logic [8:0]      DEPTH_B = 9'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state, state_nx;
  logic [ADDR_W:0] n_words;
  logic [1:0]      byte_idx;
  logic [31:0]     word;
  logic            accept;
  logic            hdr_bad;
  logic            last_word;
`ifdef LOADER_CSUM_EN
  logic [7:0]      csum;
`endif

  assign accept    = in_valid && in_ready;
  assign hdr_bad   = (in_byte == 8'd0) || ({1'b0, in_byte} > DEPTH_B);
  assign last_word = ((word_count + ONE) == n_words);
  assign mem_addr  = word_count[ADDR_W-1:0];
  assign mem_wdata = word;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (load_start) state_nx = HDR;
      HDR:   if (accept) state_nx = hdr_bad ? ERR : DATA;
      DATA:  if (accept && byte_idx == 2'd3) state_nx = WRITE;
`ifdef LOADER_CSUM_EN
      WRITE: state_nx = last_word ? CSUM : DATA;
      CSUM:  if (accept) state_nx = (in_byte == csum) ? DONE : ERR;
`else
      WRITE: state_nx = last_word ? DONE : DATA;
`endif
      DONE:  if (load_start) state_nx = HDR;
      ERR:   if (load_start) state_nx = HDR;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs are flopped from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      cpu_rst   <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
`ifdef LOADER_CSUM_EN
      in_ready  <= (state_nx == HDR) || (state_nx == DATA) || (state_nx == CSUM);
`else
      in_ready  <= (state_nx == HDR) || (state_nx == DATA);
`endif
      mem_we    <= (state_nx == WRITE);
      cpu_rst   <= (state_nx != DONE);
      load_done <= (state_nx == DONE);
      load_err  <= (state_nx == ERR);
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      word_count <= '0;
      n_words    <= '0;
      byte_idx   <= '0;
      word       <= '0;
`ifdef LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          word_count <= '0;
          byte_idx   <= '0;
          word       <= '0;
`ifdef LOADER_CSUM_EN
          csum       <= '0;
`endif
        end
        HDR: if (accept && !hdr_bad) n_words <= in_byte[ADDR_W:0];
        DATA: if (accept) begin
          word     <= {word[23:0], in_byte};
          byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CSUM_EN
          csum     <= csum ^ in_byte;
`endif
        end
        WRITE: word_count <= word_count + ONE;
        DONE, ERR: if (load_start) begin
          word_count <= '0;
          byte_idx   <= '0;
`ifdef LOADER_CSUM_EN
          csum       <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; follows LOADER_CSUM_EN when defined.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        sys_rst, load_start, in_valid;
  logic [7:0]  in_byte;
  logic        in_ready, mem_we, cpu_rst, load_done, load_err;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [4:0]  word_count;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int base;
  int wr_n = 0;
  logic [3:0]  wr_addr [0:127];
  logic [31:0] wr_data [0:127];
  logic [7:0]  pat [0:63];
  logic [7:0]  csum;
  logic [31:0] exp_word;

  prog_loader #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .sys_rst(sys_rst), .load_start(load_start), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .load_done(load_done),
    .load_err(load_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_n < 128) begin
        wr_addr[wr_n] = mem_addr;
        wr_data[wr_n] = mem_wdata;
      end
      wr_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a byte at a negedge and returns at the negedge after it is accepted.
  task automatic send(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      stalls++;
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 20) else begin
      errors++;
      $error("FAIL send_timeout observed=in_ready_low expected=accept byte=%h", b);
    end
    if (n < 20) @(negedge clk);
  endtask

  task automatic start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;

    // Reset asserted between clock edges
    #2 sys_rst = 1'b1;
    #1;
    check("rst_cpu_rst",   32'(cpu_rst),    32'h1);
    check("rst_in_ready",  32'(in_ready),   32'h0);
    check("rst_mem_we",    32'(mem_we),     32'h0);
    check("rst_load_done", 32'(load_done),  32'h0);
    check("rst_load_err",  32'(load_err),   32'h0);
    check("rst_word_count",32'(word_count), 32'h0);
    check("rst_mem_addr",  32'(mem_addr),   32'h0);
    check("rst_mem_wdata", mem_wdata,       32'h0);
    @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);

    // Single word
    base = wr_n;
    start();
    send(8'h01); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    check("w1_write_we",    32'(mem_we),   32'h1);
    check("w1_write_addr",  32'(mem_addr), 32'h0);
    check("w1_write_data",  mem_wdata,     32'h12345678);
    check("w1_write_ready", 32'(in_ready), 32'h0);
    check("w1_write_cpu",   32'(cpu_rst),  32'h1);
`ifdef LOADER_CSUM_EN
    send(8'h08);
    in_valid = 1'b0;
`else
    in_valid = 1'b0;
    @(negedge clk);
`endif
    check("w1_done",       32'(load_done),  32'h1);
    check("w1_cpu_rst",    32'(cpu_rst),    32'h0);
    check("w1_err",        32'(load_err),   32'h0);
    check("w1_word_count", 32'(word_count), 32'h1);
    check("w1_we_pulses",  32'(wr_n - base), 32'h1);
    check("w1_log_addr",   32'(wr_addr[base]), 32'h0);
    check("w1_log_data",   wr_data[base],   32'h12345678);

    // Full 16-word program with in_valid held high
    start();
    check("full_start_done", 32'(load_done), 32'h0);
    check("full_start_cpu",  32'(cpu_rst),   32'h1);
    csum = 8'h00;
    for (int i = 0; i < 64; i++) begin
      pat[i] = 8'(i * 37 + 5);
      csum   = csum ^ pat[i];
    end
    base = wr_n;
    stalls = 0;
    send(8'd16);
    for (int i = 0; i < 64; i++) send(pat[i]);
`ifdef LOADER_CSUM_EN
    send(csum);
    check("full_stalls", 32'(stalls), 32'd16);
`else
    check("full_stalls", 32'(stalls), 32'd15);
`endif
    in_valid = 1'b0;
    @(negedge clk);
    check("full_we_pulses", 32'(wr_n - base), 32'd16);
    for (int k = 0; k < 16; k++) begin
      exp_word = {pat[4*k], pat[4*k+1], pat[4*k+2], pat[4*k+3]};
      check($sformatf("full_addr%0d", k), 32'(wr_addr[base+k]), 32'(k));
      check($sformatf("full_data%0d", k), wr_data[base+k], exp_word);
    end
    check("full_done",       32'(load_done),  32'h1);
    check("full_word_count", 32'(word_count), 32'd16);

    // Bad headers
    base = wr_n;
    start();
    send(8'd0);
    in_valid = 1'b0;
    check("hdr0_err",  32'(load_err),  32'h1);
    check("hdr0_cpu",  32'(cpu_rst),   32'h1);
    check("hdr0_done", 32'(load_done), 32'h0);
    start();
    check("hdr17_err_cleared", 32'(load_err), 32'h0);
    send(8'd17);
    in_valid = 1'b0;
    @(negedge clk);
    check("hdr17_err", 32'(load_err), 32'h1);
    check("hdr17_cpu", 32'(cpu_rst),  32'h1);
    check("hdr_no_we", 32'(wr_n - base), 32'h0);

`ifdef LOADER_CSUM_EN
    // Checksum mismatch then recovery
    base = wr_n;
    start();
    send(8'h01); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h09);
    in_valid = 1'b0;
    check("csum_err",       32'(load_err),  32'h1);
    check("csum_done",      32'(load_done), 32'h0);
    check("csum_we_pulses", 32'(wr_n - base), 32'h1);
    check("csum_log_data",  wr_data[base], 32'h12345678);
    start();
    send(8'h01); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h08);
    in_valid = 1'b0;
    check("csum_retry_done", 32'(load_done), 32'h1);
    check("csum_retry_err",  32'(load_err),  32'h0);
`endif

    // Reset mid-load after two data bytes
    start();
    send(8'h01); send(8'hAA); send(8'hBB);
    in_valid = 1'b0;
    #2 sys_rst = 1'b1;
    #1;
    check("midrst_ready", 32'(in_ready),   32'h0);
    check("midrst_cpu",   32'(cpu_rst),    32'h1);
    check("midrst_we",    32'(mem_we),     32'h0);
    check("midrst_wc",    32'(word_count), 32'h0);
    check("midrst_wdata", mem_wdata,       32'h0);
    check("midrst_err",   32'(load_err),   32'h0);
    @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);
    base = wr_n;
    start();
    send(8'h01); send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE);
`ifdef LOADER_CSUM_EN
    send(8'h30);
`endif
    in_valid = 1'b0;
    @(negedge clk);
    check("fresh_we_pulses", 32'(wr_n - base), 32'h1);
    check("fresh_addr",      32'(wr_addr[base]), 32'h0);
    check("fresh_data",      wr_data[base], 32'hCAFEBABE);
    check("fresh_done",      32'(load_done), 32'h1);
    check("fresh_wc",        32'(word_count), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
